ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//  Parametrised EX->MEM pipeline boundary with valid/ready handshake, 2-entry skid buffer and flush.
//  Carries next-PC, ALU result, store data, destination register and MEM/WB control bits from EX to MEM.
//  Lets MEM stall (e.g. slow data memory) without a combinational ready path back into EX.
//  A flush (branch/jump redirect) kills both entries so squashed instructions never reach MEM.
// PARAMETERS
//  PC_W    32  width of next-PC field
//  DATA_W  32  width of ALU result and store data
//  REG_AW  5   width of destination register index
//  CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  clk                 in   1       clock, rising edge
//  rst_n               in   1       asynchronous active-low reset
//  flush               in   1       synchronous kill of all held entries
//  valid_ex            in   1       EX presents an instruction
//  ready_ex            out  1       stage can accept this cycle
//  pc_next_ex          in   PC_W    next PC
//  alu_result_ex       in   DATA_W  ALU result / address
//  read_data_2_ex      in   DATA_W  store data
//  write_register_ex   in   REG_AW  destination register
//  ctrl_ex             in   7       {branch,mem_read,mem_to_reg,mem_write,reg_write,jump,zero}
//  valid_mem           out  1       MEM-side entry valid
//  ready_mem           in   1       MEM consumes entry this cycle
//  pc_next_mem, alu_result_mem, read_data_2_mem, write_register_mem  out  as EX  payload
//  ctrl_mem            out  7       control bits, same order, gated (see below)
//  stall_cnt           out  CNT_W   cycles with valid_mem=1 and ready_mem=0
// BEHAVIOUR
//  - Storage: main entry M (drives *_mem), skid entry S; each has a valid flag.
//  - in_fire = valid_ex & ready_ex; out_fire = valid_mem & ready_mem.
//  - ready_ex = ~S.valid, from a register only (no path from ready_mem). valid_mem = M.valid.
//  - Priority each clock edge: reset > flush > transfer rules.
//  - S.valid=1: out_fire -> M<=S, S.valid<=0; else hold both. No input accepted.
//  - S.valid=0: in_fire & (~M.valid | out_fire) -> M<=in; in_fire & M.valid & ~out_fire -> S<=in;
//    no in_fire & out_fire -> M.valid<=0.
//  - Latency: 1 cycle EX->MEM when unstalled; full throughput (1/cycle) with ready_mem=1.
//  - Order preserved: S never overtakes M; no entry dropped or duplicated.
//  - flush=1: M.valid<=0, S.valid<=0; in_fire data that cycle discarded; out_fire that cycle
//    still counts as consumed by MEM. Payload regs not cleared by flush.
//  - ctrl_mem = stored ctrl & {7{valid_mem}}: bubbles never assert mem_write/reg_write/etc.
//  - stall_cnt: +1 per cycle valid_mem & ~ready_mem, saturates at 2^CNT_W-1, not cleared by flush.
//  - Reset (rst_n=0, async): M.valid=S.valid=0, all payload and ctrl_mem=0, stall_cnt=0,
//    ready_ex=1, valid_mem=0. Reset mid-stall discards both entries; first edge after release
//    behaves as empty stage.
//  - Payload registers load only on a transfer into them (no toggling on idle cycles).
// TESTING
//  1. Reset: rst_n=0 async mid-cycle -> valid_mem=0, ctrl_mem=0, stall_cnt=0, ready_ex=1 at once.
//  2. Stream: ready_mem=1, valid_ex=1, alu_result_ex=1,2,3,4 -> alu_result_mem 1,2,3,4 one
//     cycle later each, ready_ex stays 1.
//  3. Stall: send A=0x10,B=0x20,C=0x30 with ready_mem=0 -> A in M, B in S, ready_ex=0 after B,
//     C held by EX; raise ready_mem -> MEM sees A,B,C in order; stall_cnt equals stalled cycles.
//  4. Flush: M and S full, pulse flush with valid_ex=1 -> next cycle valid_mem=0, ready_ex=1,
//     ctrl_mem=0; the flushed-cycle input never appears at MEM.
//  5. Bubble gating: valid_ex=0 with ctrl_ex=7'h7F -> ctrl_mem stays 0, mem_write never asserted.
//  6. Saturation: CNT_W=4, hold valid_mem=1, ready_mem=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary: valid/ready handshake, 2-entry skid buffer, flush,
// and a saturating count of MEM stall cycles. ready_ex comes only from a register.
module ex_mem_skid_reg #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_ex,
  output logic              ready_ex,
  input  logic [PC_W-1:0]   pc_next_ex,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [DATA_W-1:0] read_data_2_ex,
  input  logic [REG_AW-1:0] write_register_ex,
  input  logic [6:0]        ctrl_ex,
  output logic              valid_mem,
  input  logic              ready_mem,
  output logic [PC_W-1:0]   pc_next_mem,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic [DATA_W-1:0] read_data_2_mem,
  output logic [REG_AW-1:0] write_register_mem,
  output logic [6:0]        ctrl_mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] wr;
    logic [6:0]        ctrl;
  } ent_t;

  ent_t in_e, m_q, s_q;
  logic m_vld, s_vld;
  logic in_fire, out_fire;

  assign in_e     = '{pc: pc_next_ex, alu: alu_result_ex, rd2: read_data_2_ex,
                      wr: write_register_ex, ctrl: ctrl_ex};
  assign ready_ex = ~s_vld;
  assign in_fire  = valid_ex & ready_ex;
  assign out_fire = m_vld & ready_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (s_vld) begin
      // Skid entry drains into main before any new input is taken.
      if (out_fire) begin
        m_q   <= s_q;
        s_vld <= 1'b0;
      end
    end else if (in_fire && (!m_vld || out_fire)) begin
      m_q   <= in_e;
      m_vld <= 1'b1;
    end else if (in_fire) begin
      s_q   <= in_e;
      s_vld <= 1'b1;
    end else if (out_fire) begin
      m_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (m_vld && !ready_mem && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign valid_mem          = m_vld;
  assign pc_next_mem        = m_q.pc;
  assign alu_result_mem     = m_q.alu;
  assign read_data_2_mem    = m_q.rd2;
  assign write_register_mem = m_q.wr;
  // Bubbles must never present live control bits to MEM.
  assign ctrl_mem           = m_q.ctrl & {7{m_vld}};

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus randomized
// traffic against a queue-based model of the two-deep buffer.
module tb_ex_mem_skid_reg;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wr;
    logic [6:0]  ctrl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid_ex = 1'b0;
  logic        ready_ex;
  logic [31:0] pc_next_ex = '0;
  logic [31:0] alu_result_ex = '0;
  logic [31:0] read_data_2_ex = '0;
  logic [4:0]  write_register_ex = '0;
  logic [6:0]  ctrl_ex = '0;
  logic        valid_mem;
  logic        ready_mem = 1'b0;
  logic [31:0] pc_next_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] read_data_2_mem;
  logic [4:0]  write_register_mem;
  logic [6:0]  ctrl_mem;
  logic [CNT_W-1:0] stall_cnt;

  int nchk = 0;
  int nerr = 0;

  ent_t q[$];
  int   mcnt = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.PC_W(32), .DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_ex(valid_ex), .ready_ex(ready_ex),
    .pc_next_ex(pc_next_ex), .alu_result_ex(alu_result_ex),
    .read_data_2_ex(read_data_2_ex), .write_register_ex(write_register_ex),
    .ctrl_ex(ctrl_ex),
    .valid_mem(valid_mem), .ready_mem(ready_mem),
    .pc_next_mem(pc_next_mem), .alu_result_mem(alu_result_mem),
    .read_data_2_mem(read_data_2_mem), .write_register_mem(write_register_mem),
    .ctrl_mem(ctrl_mem), .stall_cnt(stall_cnt)
  );

  task automatic drive(input logic v, input logic [31:0] alu, input logic [6:0] ctrl);
    valid_ex          = v;
    alu_result_ex     = alu;
    pc_next_ex        = $urandom;
    read_data_2_ex    = $urandom;
    write_register_ex = 5'($urandom);
    ctrl_ex           = ctrl;
  endtask

  // Advance one clock edge; model = FIFO of at most two in-flight entries.
  task automatic tick();
    bit   inf, outf, stl;
    ent_t e;
    inf  = valid_ex && (q.size() < 2);
    outf = (q.size() > 0) && ready_mem;
    stl  = (q.size() > 0) && !ready_mem;
    e    = '{pc: pc_next_ex, alu: alu_result_ex, rd2: read_data_2_ex,
             wr: write_register_ex, ctrl: ctrl_ex};
    @(posedge clk);
    if (stl && mcnt < CMAX) mcnt++;
    if (flush) q.delete();
    else begin
      if (outf) q.delete(0);
      if (inf) q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; ready_mem = 1'b0;
    drive(1'b0, 32'h0, 7'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    mcnt = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    ready_mem = 1'b0;
    drive(1'b1, 32'hAA, 7'h7F); tick();
    drive(1'b1, 32'hBB, 7'h7F); tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    nchk++;
    if (valid_mem !== 1'b0 || ctrl_mem !== 7'h0 || stall_cnt !== '0 || ready_ex !== 1'b1 ||
        alu_result_mem !== 32'h0) begin
      nerr++;
      $display("FAIL reset: got vm=%b ctrl=%h cnt=%0d rdy=%b alu=%h, want 0 0 0 1 0",
               valid_mem, ctrl_mem, stall_cnt, ready_ex, alu_result_mem);
    end
    q.delete(); mcnt = 0;
    drive(1'b0, 32'h0, 7'h0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    drive(1'b1, 32'h5, 7'h01); ready_mem = 1'b1; tick();
    nchk++;
    if (valid_mem !== 1'b1 || alu_result_mem !== 32'h5 || stall_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_release: got vm=%b alu=%h cnt=%0d, want 1 5 0",
               valid_mem, alu_result_mem, stall_cnt);
    end
  endtask

  task automatic test_stream();
    do_reset();
    ready_mem = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 7'h0A);
      tick();
      nchk++;
      if (valid_mem !== 1'b1 || alu_result_mem !== 32'(i) || ready_ex !== 1'b1 ||
          pc_next_mem !== q[0].pc || read_data_2_mem !== q[0].rd2) begin
        nerr++;
        $display("FAIL stream[%0d]: got vm=%b alu=%h rdy=%b, want 1 %h 1",
                 i, valid_mem, alu_result_mem, ready_ex, i);
      end
    end
    drive(1'b0, 32'h0, 7'h0); tick();
    nchk++;
    if (valid_mem !== 1'b0) begin
      nerr++; $display("FAIL stream_drain: got vm=%b want 0", valid_mem);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h10; exp_seq[1] = 32'h20; exp_seq[2] = 32'h30;
    do_reset();
    ready_mem = 1'b0;
    drive(1'b1, 32'h10, 7'h12); tick();
    drive(1'b1, 32'h20, 7'h13); tick();
    nchk++;
    if (ready_ex !== 1'b0 || alu_result_mem !== 32'h10) begin
      nerr++; $display("FAIL stall_full: got rdy=%b alu=%h, want 0 10", ready_ex, alu_result_mem);
    end
    drive(1'b1, 32'h30, 7'h14); tick(); tick();
    nchk++;
    if (ready_ex !== 1'b0 || alu_result_mem !== 32'h10 || stall_cnt !== 4'd3) begin
      nerr++;
      $display("FAIL stall_hold: got rdy=%b alu=%h cnt=%0d, want 0 10 3",
               ready_ex, alu_result_mem, stall_cnt);
    end
    ready_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (valid_mem !== 1'b1 || alu_result_mem !== exp_seq[i]) begin
        nerr++;
        $display("FAIL stall_order[%0d]: got vm=%b alu=%h, want 1 %h",
                 i, valid_mem, alu_result_mem, exp_seq[i]);
      end
      tick();
      if (i == 1) drive(1'b0, 32'h0, 7'h0);
    end
    nchk++;
    if (valid_mem !== 1'b0 || stall_cnt !== 4'(mcnt) || mcnt != 3) begin
      nerr++; $display("FAIL stall_end: got vm=%b cnt=%0d, want 0 3", valid_mem, stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ready_mem = 1'b0;
    drive(1'b1, 32'hA1, 7'h7F); tick();
    drive(1'b1, 32'hA2, 7'h7F); tick();
    drive(1'b1, 32'hA3, 7'h7F); flush = 1'b1; tick();
    flush = 1'b0;
    nchk++;
    if (valid_mem !== 1'b0 || ready_ex !== 1'b1 || ctrl_mem !== 7'h0) begin
      nerr++;
      $display("FAIL flush_full: got vm=%b rdy=%b ctrl=%h, want 0 1 0", valid_mem, ready_ex, ctrl_mem);
    end
    // Flush while accepting and consuming: input dropped, nothing left behind.
    drive(1'b1, 32'hB1, 7'h05); ready_mem = 1'b1; tick();
    drive(1'b1, 32'hB2, 7'h05); flush = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 32'h0, 7'h0);
    nchk++;
    if (valid_mem !== 1'b0 || ctrl_mem !== 7'h0) begin
      nerr++; $display("FAIL flush_inflight: got vm=%b ctrl=%h, want 0 0", valid_mem, ctrl_mem);
    end
    tick();
    nchk++;
    if (valid_mem !== 1'b0 || alu_result_mem === 32'hB2) begin
      nerr++; $display("FAIL flush_discard: got vm=%b alu=%h, want 0 not B2", valid_mem, alu_result_mem);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    ready_mem = 1'b1;
    drive(1'b1, 32'h77, 7'h7F); tick();
    nchk++;
    if (ctrl_mem !== 7'h7F) begin
      nerr++; $display("FAIL bubble_live: got ctrl=%h want 7f", ctrl_mem);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h99, 7'h7F); tick();
      nchk++;
      if (ctrl_mem !== 7'h0 || valid_mem !== 1'b0 || ctrl_mem[3] !== 1'b0) begin
        nerr++; $display("FAIL bubble[%0d]: got ctrl=%h vm=%b, want 0 0", i, ctrl_mem, valid_mem);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ready_mem = 1'b0;
    drive(1'b1, 32'h42, 7'h01); tick();
    drive(1'b0, 32'h0, 7'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      nchk++;
      if (stall_cnt !== 4'(mcnt)) begin
        nerr++; $display("FAIL sat_step[%0d]: got cnt=%0d want %0d", i, stall_cnt, mcnt);
      end
    end
    nchk++;
    if (stall_cnt !== 4'd15) begin
      nerr++; $display("FAIL saturation: got cnt=%0d want 15", stall_cnt);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    nchk++;
    if (stall_cnt !== 4'd15) begin
      nerr++; $display("FAIL sat_flush: got cnt=%0d want 15", stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 7'($urandom));
      ready_mem = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
      nchk++;
      if (valid_mem !== (q.size() > 0) || ready_ex !== (q.size() < 2) ||
          stall_cnt !== 4'(mcnt) ||
          ctrl_mem !== ((q.size() > 0) ? q[0].ctrl : 7'h0)) begin
        nerr++;
        $display("FAIL random_ctl[%0d]: got vm=%b rdy=%b cnt=%0d ctrl=%h, want occ=%0d cnt=%0d",
                 i, valid_mem, ready_ex, stall_cnt, ctrl_mem, q.size(), mcnt);
      end else if (q.size() > 0 &&
                   {pc_next_mem, alu_result_mem, read_data_2_mem, write_register_mem} !==
                   {q[0].pc, q[0].alu, q[0].rd2, q[0].wr}) begin
        nerr++;
        $display("FAIL random_data[%0d]: got alu=%h pc=%h, want alu=%h pc=%h",
                 i, alu_result_mem, pc_next_mem, q[0].alu, q[0].pc);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
